img_rsz_blk_sched: RTL and testbench
====================================

Name: img_rsz_blk_sched

Overview:
- Sequencing controller for the resizing block buffer. It issues completed blocks to the resizing compute engine in raster order.
- It then streams each executed block's resized pixel out on a valid/ready interface, in raster order.
- For every forwarded block it generates the one-hot flush strobes that clear that block's executed flag.
- It sits between the block buffer (BlkIsEnough/BlkIsExec producer) and the downstream resized-pixel consumer.

Parameters:
- RSZ_IMG_WIDTH_SIZE, 8, resized image width in blocks (U); power of 2, >=2
- RSZ_IMG_HEIGHT_SIZE, 8, resized image height in blocks (V); power of 2, >=2
- PXL_PRIM_COLOR_NUM, 1, primary colours per pixel
- PXL_PRIM_COLOR_W, 8, bits per primary colour

Ports:
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- SchedEn  in  1  1 = new compute issues permitted
- BlkIsEnough  in  [RSZ_IMG_WIDTH_SIZE-1:0] x RSZ_IMG_HEIGHT_SIZE (unpacked)  block has collected all its pixels
- CeReqRdy  in  1  compute engine can accept a block this cycle
- CompBlkXMsk  out  RSZ_IMG_WIDTH_SIZE  one-hot column of the issue pointer
- CompBlkYMsk  out  RSZ_IMG_HEIGHT_SIZE  one-hot row of the issue pointer
- CompBlkEn  out  1  issue strobe, 1 cycle per block
- BlkIsExec  in  [RSZ_IMG_WIDTH_SIZE-1:0] x RSZ_IMG_HEIGHT_SIZE (unpacked)  block resized value is valid
- SelRszPxlData  in  PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W  resized value of the block addressed by FlushBlkX/YMsk (external one-hot mux, combinational)
- FlushBlkXMsk  out  RSZ_IMG_WIDTH_SIZE  one-hot column of the forward pointer
- FlushBlkYMsk  out  RSZ_IMG_HEIGHT_SIZE  one-hot row of the forward pointer
- FlushVld  out  1  flush strobe for the forward-pointer block
- RszPxlData  out  PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W  resized pixel
- RszPxlVld  out  1  resized pixel valid
- RszPxlRdy  in  1  downstream ready
- FrameDone  out  1  1-cycle pulse when the last block (U-1,V-1) is forwarded

Behaviour:
- Reset (Reset=0, asynchronous):
  - Issue pointer (iu,iv)=(0,0); forward pointer (fu,fv)=(0,0); forward FSM=WAIT.
  - RszPxlData=0, RszPxlVld=0, FlushVld=0, FrameDone=0.
  - CompBlkEn=0; CompBlkXMsk/YMsk=onehot(0); FlushBlkXMsk/YMsk=onehot(0).
  - Reset asserted mid-frame discards all progress; no partial handshake completes.
- Issue path (combinational on the registered pointer, 0-cycle latency):
  - CompBlkXMsk=1<<iu; CompBlkYMsk=1<<iv.
  - CompBlkEn = SchedEn & CeReqRdy & BlkIsEnough[iv][iu].
  - When CompBlkEn=1, the pointer advances on that edge: iu+1; at iu=U-1, iu->0 and iv+1; at (U-1,V-1) it wraps to (0,0).
  - Strict raster order: a ready block other than (iu,iv) is never issued, even if the pointer block is not ready.
  - Back-to-back issues are allowed, one per cycle.
  - Because the pointer advances on issue, a block is never issued twice, even though BlkIsEnough clears one cycle later.
- Forward FSM, two states:
  - FlushBlkXMsk=1<<fu and FlushBlkYMsk=1<<fv at all times.
  - WAIT: if BlkIsExec[fv][fu]=1, register RszPxlData<=SelRszPxlData, set RszPxlVld<=1, go to SEND. Otherwise stay.
  - SEND: RszPxlVld=1 and RszPxlData are held stable until RszPxlRdy=1.
  - On the handshake cycle (Vld&Rdy): FlushVld=1 (combinational, masks still on the old pointer); the pointer advances with the same wrap rule; RszPxlVld<=0; go to WAIT.
  - FrameDone=1 on the handshake cycle when (fu,fv)=(U-1,V-1).
- Latency and throughput:
  - Latency from BlkIsExec rising to RszPxlVld is 1 cycle.
  - Maximum throughput is 1 pixel per 2 cycles.
- Simultaneous events:
  - Issue and forward pointers are independent and may advance in the same cycle.
  - Forward never overtakes issue by construction, since BlkIsExec is set only after compute.
  - BlkIsExec on a block other than (fu,fv) is ignored until the pointer reaches it.
- SchedEn=0 blocks new issues only. An in-flight SEND still completes.
- Pointers are log2-width counters; the one-hot masks are decoded from them and carry exactly one bit set at all times.

Test Plan:
1. 2x2 config; assert BlkIsEnough[0][0..1]=1 with CeReqRdy=1 -> CompBlkEn high 2 consecutive cycles, XMsk=01 then 10, YMsk=01 both cycles; pointer ends at (0,1).
2. BlkIsEnough[0][1]=1 only, pointer at (0,0) -> CompBlkEn stays 0 for 20 cycles; setting BlkIsEnough[0][0]=1 -> issue (0,0) next edge, then (1,0) the following cycle.
3. CeReqRdy=0 or SchedEn=0 with block ready -> no CompBlkEn; deassert -> issue on the same cycle.
4. BlkIsExec[0][0]=1 with SelRszPxlData=0xA5 and RszPxlRdy=0 for 5 cycles -> RszPxlVld=1 with data 0xA5 held; Rdy=1 -> FlushVld=1 with masks (01,01) that cycle, then Vld=0.
5. Forward all 4 blocks of a 2x2 frame with Rdy=1 -> 4 pixels in raster order, FrameDone single pulse on the 4th handshake, pointers return to (0,0).
6. Drop Reset to 0 during SEND -> RszPxlVld=0 immediately (asynchronous), no FlushVld; after release, pointers are at (0,0).

Source files
------------

// File: rtl/img_rsz_blk_sched_if.sv
// Resized-pixel stream between the block scheduler and the downstream consumer.
// A transfer happens on the rising Clk edge where RszPxlVld & RszPxlRdy are both 1;
// once RszPxlVld is raised, RszPxlData stays stable and RszPxlVld stays high until that edge.
interface img_rsz_blk_sched_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] RszPxlData;
  logic              RszPxlVld;
  logic              RszPxlRdy;

  modport master (
    output RszPxlData,
    output RszPxlVld,
    input  RszPxlRdy
  );

  modport slave (
    input  RszPxlData,
    input  RszPxlVld,
    output RszPxlRdy
  );

endinterface

// File: rtl/img_rsz_blk_sched.sv
// Block buffer sequencer: issues ready blocks to the compute engine in raster order,
// then forwards each executed block's resized pixel downstream and flushes it.
module img_rsz_blk_sched #(
  parameter int RSZ_IMG_WIDTH_SIZE  = 8,
  parameter int RSZ_IMG_HEIGHT_SIZE = 8,
  parameter int PXL_PRIM_COLOR_NUM  = 1,
  parameter int PXL_PRIM_COLOR_W    = 8
) (
  input  logic                                           Clk,
  input  logic                                           Reset,
  input  logic                                           SchedEn,
  input  logic [RSZ_IMG_WIDTH_SIZE-1:0]                  BlkIsEnough [RSZ_IMG_HEIGHT_SIZE],
  input  logic                                           CeReqRdy,
  output logic [RSZ_IMG_WIDTH_SIZE-1:0]                  CompBlkXMsk,
  output logic [RSZ_IMG_HEIGHT_SIZE-1:0]                 CompBlkYMsk,
  output logic                                           CompBlkEn,
  input  logic [RSZ_IMG_WIDTH_SIZE-1:0]                  BlkIsExec [RSZ_IMG_HEIGHT_SIZE],
  input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] SelRszPxlData,
  output logic [RSZ_IMG_WIDTH_SIZE-1:0]                  FlushBlkXMsk,
  output logic [RSZ_IMG_HEIGHT_SIZE-1:0]                 FlushBlkYMsk,
  output logic                                           FlushVld,
  img_rsz_blk_sched_if.master                            RszPxl,
  output logic                                           FrameDone,
  output logic                                           DbgFwdState
);

  localparam int U   = RSZ_IMG_WIDTH_SIZE;
  localparam int V   = RSZ_IMG_HEIGHT_SIZE;
  localparam int UW  = $clog2(U);
  localparam int VW  = $clog2(V);
  localparam int PW  = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;

  localparam logic [UW-1:0] U_LAST = UW'(U - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V - 1);

  typedef enum logic {
    FWD_WAIT = 1'b0,
    FWD_SEND = 1'b1
  } fwd_state_e;

  // Issue pointer
  logic [UW-1:0] issueU;
  logic [VW-1:0] issueV;

  // Forward pointer and output registers
  logic [UW-1:0] fwdU;
  logic [VW-1:0] fwdV;
  fwd_state_e    fwdState;
  fwd_state_e    fwdStateNxt;
  logic          fwdLoad;
  logic          fwdHs;
  logic [PW-1:0] pxlData;
  logic          pxlVld;

  // Issue path: decoded straight off the registered pointer, so an issue costs no latency.
  assign CompBlkXMsk = U'(1) << issueU;
  assign CompBlkYMsk = V'(1) << issueV;
  assign CompBlkEn   = Reset & SchedEn & CeReqRdy & BlkIsEnough[issueV][issueU];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      issueU <= '0;
      issueV <= '0;
    end else if (CompBlkEn) begin
      if (issueU == U_LAST) begin
        issueU <= '0;
        issueV <= (issueV == V_LAST) ? '0 : issueV + VW'(1);
      end else begin
        issueU <= issueU + UW'(1);
      end
    end
  end

  // Forward FSM: next-state and strobes
  always_comb begin
    fwdStateNxt = fwdState;
    fwdLoad     = 1'b0;
    fwdHs       = 1'b0;
    case (fwdState)
      FWD_WAIT: begin
        if (BlkIsExec[fwdV][fwdU]) begin
          fwdLoad     = 1'b1;
          fwdStateNxt = FWD_SEND;
        end
      end
      FWD_SEND: begin
        if (RszPxl.RszPxlRdy) begin
          fwdHs       = 1'b1;
          fwdStateNxt = FWD_WAIT;
        end
      end
      default: fwdStateNxt = FWD_WAIT;
    endcase
  end

  // Forward FSM: state, pointer and the registered pixel
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fwdState <= FWD_WAIT;
      fwdU     <= '0;
      fwdV     <= '0;
      pxlData  <= '0;
      pxlVld   <= 1'b0;
    end else begin
      fwdState <= fwdStateNxt;
      if (fwdLoad) begin
        pxlData <= SelRszPxlData;
        pxlVld  <= 1'b1;
      end
      if (fwdHs) begin
        pxlVld <= 1'b0;
        if (fwdU == U_LAST) begin
          fwdU <= '0;
          fwdV <= (fwdV == V_LAST) ? '0 : fwdV + VW'(1);
        end else begin
          fwdU <= fwdU + UW'(1);
        end
      end
    end
  end

  // The flush masks still address the block being handed off during the handshake cycle.
  assign FlushBlkXMsk      = U'(1) << fwdU;
  assign FlushBlkYMsk      = V'(1) << fwdV;
  assign FlushVld          = fwdHs;
  assign FrameDone         = fwdHs & (fwdU == U_LAST) & (fwdV == V_LAST);
  assign RszPxl.RszPxlData = pxlData;
  assign RszPxl.RszPxlVld  = pxlVld;
  assign DbgFwdState       = fwdState;

endmodule

// File: tb/tb_img_rsz_blk_sched.sv
// Bench for img_rsz_blk_sched on a 2x2 block grid: directed scenarios with literal
// expectations, then a randomized block-buffer environment checked against a block-index model.
module tb_img_rsz_blk_sched;

  localparam int U    = 2;
  localparam int V    = 2;
  localparam int NB   = U * V;
  localparam int DW   = 8;
  localparam int NCYC = 800;
  localparam int NDRN = 80;

  // Clock / reset
  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic          SchedEn;
  logic          CeReqRdy;
  logic [U-1:0]  BlkIsEnough [V];
  logic [U-1:0]  BlkIsExec [V];
  logic [DW-1:0] SelRszPxlData;
  logic [U-1:0]  CompBlkXMsk;
  logic [V-1:0]  CompBlkYMsk;
  logic          CompBlkEn;
  logic [U-1:0]  FlushBlkXMsk;
  logic [V-1:0]  FlushBlkYMsk;
  logic          FlushVld;
  logic          FrameDone;
  logic          DbgFwdState;

  img_rsz_blk_sched_if #(.DATA_W(DW)) rszPxl ();

  img_rsz_blk_sched #(
    .RSZ_IMG_WIDTH_SIZE (U),
    .RSZ_IMG_HEIGHT_SIZE(V),
    .PXL_PRIM_COLOR_NUM (1),
    .PXL_PRIM_COLOR_W   (DW)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .SchedEn      (SchedEn),
    .BlkIsEnough  (BlkIsEnough),
    .CeReqRdy     (CeReqRdy),
    .CompBlkXMsk  (CompBlkXMsk),
    .CompBlkYMsk  (CompBlkYMsk),
    .CompBlkEn    (CompBlkEn),
    .BlkIsExec    (BlkIsExec),
    .SelRszPxlData(SelRszPxlData),
    .FlushBlkXMsk (FlushBlkXMsk),
    .FlushBlkYMsk (FlushBlkYMsk),
    .FlushVld     (FlushVld),
    .RszPxl       (rszPxl.master),
    .FrameDone    (FrameDone),
    .DbgFwdState  (DbgFwdState)
  );

  // Block buffer contents and its external one-hot read mux
  logic [DW-1:0] pix [V][U];
  always_comb begin
    SelRszPxlData = '0;
    for (int v = 0; v < V; v++)
      for (int u = 0; u < U; u++)
        if (FlushBlkYMsk[v] && FlushBlkXMsk[u]) SelRszPxlData = SelRszPxlData | pix[v][u];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int blk_idx(input logic [U-1:0] x, input logic [V-1:0] y);
    int r;
    r = 0;
    for (int u = 0; u < U; u++) if (x[u]) r = r + u;
    for (int v = 0; v < V; v++) if (y[v]) r = r + v * U;
    return r;
  endfunction

  // Reference model: raster block indices plus one pending pixel slot
  int            mIssue;
  int            mFwd;
  bit            mVld;
  logic [DW-1:0] mData;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mIssue = 0;
      mFwd   = 0;
      mVld   = 0;
      mData  = '0;
    end else begin
      if (SchedEn && CeReqRdy && BlkIsEnough[mIssue / U][mIssue % U])
        mIssue = (mIssue + 1) % NB;
      if (mVld && rszPxl.RszPxlRdy) begin
        mVld = 0;
        mFwd = (mFwd + 1) % NB;
      end else if (!mVld && BlkIsExec[mFwd / U][mFwd % U]) begin
        mVld  = 1;
        mData = pix[mFwd / U][mFwd % U];
      end
    end
  end

  // Scoreboard: pixels in issue order, popped at each forward handshake
  logic [DW-1:0] exp_q[$];
  bit            sbOn = 0;

  // Compare process: every cycle, DUT against the model
  always @(negedge Clk) begin
    int            iu, iv, fu, fv;
    logic          eEn, eHs;
    logic [DW-1:0] eq;
    iu  = mIssue % U;
    iv  = mIssue / U;
    fu  = mFwd % U;
    fv  = mFwd / U;
    eEn = Reset && SchedEn && CeReqRdy && BlkIsEnough[iv][iu];
    eHs = Reset && mVld && rszPxl.RszPxlRdy;
    check("m_comp_en",   CompBlkEn,         eEn);
    check("m_comp_xmsk", CompBlkXMsk,       1 << iu);
    check("m_comp_ymsk", CompBlkYMsk,       1 << iv);
    check("m_flush_x",   FlushBlkXMsk,      1 << fu);
    check("m_flush_y",   FlushBlkYMsk,      1 << fv);
    check("m_flush_vld", FlushVld,          eHs);
    check("m_frame",     FrameDone,         eHs && (mFwd == NB - 1));
    check("m_pxl_vld",   rszPxl.RszPxlVld,  mVld);
    if (mVld || !Reset) check("m_pxl_data", rszPxl.RszPxlData, mData);
    if (sbOn && rszPxl.RszPxlVld && rszPxl.RszPxlRdy) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 1);
      end else begin
        eq = exp_q.pop_front();
        check("sb_data", rszPxl.RszPxlData, eq);
      end
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    SchedEn          = 1'b0;
    CeReqRdy         = 1'b0;
    rszPxl.RszPxlRdy = 1'b0;
    for (int v = 0; v < V; v++) begin
      BlkIsEnough[v] = '0;
      BlkIsExec[v]   = '0;
      for (int u = 0; u < U; u++) pix[v][u] = '0;
    end
  endtask

  task automatic reset_pulse();
    Reset = 1'b0;
    cyc();
    cyc();
    Reset = 1'b1;
  endtask

  logic [DW-1:0] t5Data [NB] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [U-1:0]  t5X    [NB] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [V-1:0]  t5Y    [NB] = '{2'b01, 2'b01, 2'b10, 2'b10};

  int st  [NB];
  int cnt [NB];
  int frames = 0;

  initial begin
    int isK, hsK;
    bit fill;
    clear_inputs();

    // Reset values
    cyc();
    cyc();
    @(negedge Clk);
    check("rst_comp_en", CompBlkEn, 0);
    check("rst_comp_x",  CompBlkXMsk, 2'b01);
    check("rst_comp_y",  CompBlkYMsk, 2'b01);
    check("rst_flush_x", FlushBlkXMsk, 2'b01);
    check("rst_flush_y", FlushBlkYMsk, 2'b01);
    check("rst_vld",     rszPxl.RszPxlVld, 0);
    check("rst_data",    rszPxl.RszPxlData, 0);
    check("rst_flush",   FlushVld, 0);
    check("rst_frame",   FrameDone, 0);
    cyc();
    Reset = 1'b1;

    // 1: two back-to-back issues along row 0
    SchedEn = 1'b1; CeReqRdy = 1'b1; BlkIsEnough[0] = 2'b11;
    @(negedge Clk);
    check("t1_en0", CompBlkEn, 1); check("t1_x0", CompBlkXMsk, 2'b01); check("t1_y0", CompBlkYMsk, 2'b01);
    cyc();
    @(negedge Clk);
    check("t1_en1", CompBlkEn, 1); check("t1_x1", CompBlkXMsk, 2'b10); check("t1_y1", CompBlkYMsk, 2'b01);
    cyc();
    BlkIsEnough[0] = 2'b00;
    @(negedge Clk);
    check("t1_en2", CompBlkEn, 0); check("t1_x2", CompBlkXMsk, 2'b01); check("t1_y2", CompBlkYMsk, 2'b10);

    // 2: a ready block past the pointer is never issued
    cyc();
    reset_pulse();
    SchedEn = 1'b1; CeReqRdy = 1'b1; BlkIsEnough[0] = 2'b10;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("t2_hold", CompBlkEn, 0);
      cyc();
    end
    BlkIsEnough[0] = 2'b11;
    @(negedge Clk);
    check("t2_en0", CompBlkEn, 1); check("t2_x0", CompBlkXMsk, 2'b01);
    cyc();
    @(negedge Clk);
    check("t2_en1", CompBlkEn, 1); check("t2_x1", CompBlkXMsk, 2'b10);
    cyc();
    BlkIsEnough[0] = 2'b00;

    // 3: CeReqRdy and SchedEn gate the issue combinationally
    BlkIsEnough[1] = 2'b01; CeReqRdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("t3_cerdy", CompBlkEn, 0);
      cyc();
    end
    CeReqRdy = 1'b1; SchedEn = 1'b0;
    @(negedge Clk);
    check("t3_schen", CompBlkEn, 0);
    #1;
    SchedEn = 1'b1;
    #1;
    check("t3_same", CompBlkEn, 1); check("t3_x", CompBlkXMsk, 2'b01); check("t3_y", CompBlkYMsk, 2'b10);
    cyc();
    BlkIsEnough[1] = 2'b00; SchedEn = 1'b0;

    // 4: pixel held while downstream stalls, flushed on the handshake
    pix[0][0] = 8'hA5; BlkIsExec[0] = 2'b01; rszPxl.RszPxlRdy = 1'b0;
    @(negedge Clk);
    check("t4_lat", rszPxl.RszPxlVld, 0);
    cyc();
    pix[0][0] = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("t4_vld", rszPxl.RszPxlVld, 1); check("t4_data", rszPxl.RszPxlData, 8'hA5);
      check("t4_noflush", FlushVld, 0);
      cyc();
    end
    rszPxl.RszPxlRdy = 1'b1;
    @(negedge Clk);
    check("t4_flush", FlushVld, 1); check("t4_fx", FlushBlkXMsk, 2'b01); check("t4_fy", FlushBlkYMsk, 2'b01);
    check("t4_frame", FrameDone, 0);
    cyc();
    rszPxl.RszPxlRdy = 1'b0; BlkIsExec[0] = 2'b00;
    @(negedge Clk);
    check("t4_vld_off", rszPxl.RszPxlVld, 0); check("t4_fx_next", FlushBlkXMsk, 2'b10);

    // 6: asynchronous reset in the middle of SEND
    cyc();
    pix[0][1] = 8'h5A; BlkIsExec[0] = 2'b10;
    cyc();
    @(negedge Clk);
    check("t6_vld", rszPxl.RszPxlVld, 1); check("t6_data", rszPxl.RszPxlData, 8'h5A);
    @(posedge Clk);
    #3;
    Reset = 1'b0;
    #1;
    check("t6_vld_rst", rszPxl.RszPxlVld, 0); check("t6_data_rst", rszPxl.RszPxlData, 0);
    rszPxl.RszPxlRdy = 1'b1;
    #1;
    check("t6_noflush", FlushVld, 0); check("t6_fx", FlushBlkXMsk, 2'b01);
    check("t6_cx", CompBlkXMsk, 2'b01); check("t6_cy", CompBlkYMsk, 2'b01);
    BlkIsExec[0] = 2'b00; rszPxl.RszPxlRdy = 1'b0;
    cyc();
    Reset = 1'b1;
    @(negedge Clk);
    check("t6_post_vld", rszPxl.RszPxlVld, 0); check("t6_post_fy", FlushBlkYMsk, 2'b01);

    // 5: full 2x2 frame forwarded with downstream always ready
    cyc();
    for (int k = 0; k < NB; k++) pix[k / U][k % U] = t5Data[k];
    for (int v = 0; v < V; v++) BlkIsExec[v] = 2'b11;
    rszPxl.RszPxlRdy = 1'b1;
    for (int k = 0; k < NB; k++) begin
      @(negedge Clk);
      check("t5_gap_vld", rszPxl.RszPxlVld, 0); check("t5_gap_frame", FrameDone, 0);
      cyc();
      @(negedge Clk);
      check("t5_data", rszPxl.RszPxlData, t5Data[k]); check("t5_flush", FlushVld, 1);
      check("t5_fx", FlushBlkXMsk, t5X[k]); check("t5_fy", FlushBlkYMsk, t5Y[k]);
      check("t5_frame", FrameDone, k == NB - 1);
      cyc();
    end
    for (int v = 0; v < V; v++) BlkIsExec[v] = 2'b00;
    @(negedge Clk);
    check("t5_wrap_fx", FlushBlkXMsk, 2'b01); check("t5_wrap_fy", FlushBlkYMsk, 2'b01);
    check("t5_wrap_frame", FrameDone, 0);

    // Randomized block-buffer environment
    cyc();
    clear_inputs();
    reset_pulse();
    for (int k = 0; k < NB; k++) begin st[k] = 0; cnt[k] = 0; end
    exp_q.delete();
    sbOn = 1;
    for (int c = 0; c < NCYC + NDRN; c++) begin
      fill = (c < NCYC);
      @(negedge Clk);
      isK = CompBlkEn ? blk_idx(CompBlkXMsk, CompBlkYMsk) : -1;
      hsK = FlushVld  ? blk_idx(FlushBlkXMsk, FlushBlkYMsk) : -1;
      if (isK >= 0) exp_q.push_back(pix[isK / U][isK % U]);
      if (FrameDone) frames++;
      cyc();
      if (isK >= 0) begin
        BlkIsEnough[isK / U][isK % U] = 1'b0;
        st[isK]  = 2;
        cnt[isK] = $urandom_range(0, 3);
      end
      if (hsK >= 0) begin
        BlkIsExec[hsK / U][hsK % U] = 1'b0;
        st[hsK] = 0;
      end
      for (int k = 0; k < NB; k++) begin
        if (st[k] == 0 && fill && $urandom_range(0, 2) == 0) begin
          pix[k / U][k % U]         = DW'($urandom_range(0, 255));
          BlkIsEnough[k / U][k % U] = 1'b1;
          st[k] = 1;
        end else if (st[k] == 2) begin
          if (cnt[k] == 0) begin
            BlkIsExec[k / U][k % U] = 1'b1;
            st[k] = 3;
          end else begin
            cnt[k]--;
          end
        end
      end
      SchedEn          = fill ? ($urandom_range(0, 7) != 0) : 1'b1;
      CeReqRdy         = fill ? ($urandom_range(0, 3) != 0) : 1'b1;
      rszPxl.RszPxlRdy = fill ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    @(negedge Clk);
    check("sb_drain", 32'(exp_q.size()), 0);
    check("frame_progress", 32'(frames > 0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
